// File: rtl/conv_unit_param.sv
// Sequential-MAC convolution unit: one filter over IFM_DEPTH channels per output pixel,
// followed by bias, fixed-point rescale, saturation and optional ReLU.
module conv_unit_param #(
    parameter int DATA_WIDTH      = 16,
    parameter int FRAC_BITS       = 8,
    parameter int KERNAL_SIZE     = 5,
    parameter int IFM_DEPTH       = 6,
    parameter int CEIL_FILTERS    = 16,
    parameter int ADDRESS_SIZE_WM = $clog2(KERNAL_SIZE*KERNAL_SIZE*IFM_DEPTH*CEIL_FILTERS),
    parameter int ACC_WIDTH       = 2*DATA_WIDTH + $clog2(KERNAL_SIZE*KERNAL_SIZE*IFM_DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  wm_wr_en,
    input  logic [ADDRESS_SIZE_WM-1:0]            wm_wr_addr,
    input  logic [DATA_WIDTH-1:0]                 riscv_data,
    input  logic                                  start,
    input  logic [$clog2(CEIL_FILTERS)-1:0]       filter_sel,
    input  logic [DATA_WIDTH-1:0]                 data_bias,
    input  logic                                  relu_enable,
    input  logic [KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH-1:0] if_window,
    input  logic                                  if_valid,
    output logic                                  if_ready,
    output logic                                  busy,
    output logic                                  out_valid,
    output logic [DATA_WIDTH-1:0]                 unit_data_out
);

    localparam int TAPS     = KERNAL_SIZE * KERNAL_SIZE;
    localparam int WM_DEPTH = TAPS * IFM_DEPTH * CEIL_FILTERS;
    localparam int CNT_W    = $clog2(TAPS + 1);
    localparam int CH_W     = $clog2(IFM_DEPTH + 1);
    localparam int FSEL_W   = $clog2(CEIL_FILTERS);
    localparam int SUM_W    = ACC_WIDTH + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX = (SUM_W'(1) <<< (DATA_WIDTH-1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = -(SUM_W'(1) <<< (DATA_WIDTH-1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_IF,
        S_MAC,
        S_OUT
    } state_t;

    state_t                        r_state, w_next_state;
    logic [CNT_W-1:0]              r_cnt;
    logic [CH_W-1:0]               r_ch;
    logic [FSEL_W-1:0]             r_filter;
    logic signed [DATA_WIDTH-1:0]  r_bias;
    logic                          r_relu;
    logic signed [ACC_WIDTH-1:0]   r_acc;

    logic [DATA_WIDTH-1:0]         r_wm [WM_DEPTH];
    logic [DATA_WIDTH-1:0]         r_rd_data;
    logic signed [DATA_WIDTH-1:0]  r_w [TAPS];
    logic signed [DATA_WIDTH-1:0]  r_x [TAPS];

    logic                          w_last_tap;
    logic                          w_last_ch;
    logic [31:0]                   w_rd_addr;
    logic [CNT_W-1:0]              w_w_idx;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [SUM_W-1:0]       w_sum;
    logic [DATA_WIDTH-1:0]         w_result;

    assign w_last_tap = (r_cnt == CNT_W'(TAPS - 1));
    assign w_last_ch  = (r_ch == CH_W'(IFM_DEPTH - 1));
    assign w_rd_addr  = (32'(r_filter) * IFM_DEPTH + 32'(r_ch)) * TAPS + 32'(r_cnt);
    assign w_w_idx    = r_cnt - CNT_W'(1);
    assign w_prod     = r_w[r_cnt] * r_x[r_cnt];
    assign w_sum      = SUM_W'(r_acc >>> FRAC_BITS) + SUM_W'(r_bias);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        if_ready     = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:    if (start) w_next_state = S_LOAD;
            S_LOAD:    if (r_cnt == CNT_W'(TAPS)) w_next_state = S_WAIT_IF;
            S_WAIT_IF: begin
                if_ready = 1'b1;
                if (if_valid) w_next_state = S_MAC;
            end
            S_MAC:     if (w_last_tap) w_next_state = w_last_ch ? S_OUT : S_LOAD;
            S_OUT:     w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_result = w_sum[DATA_WIDTH-1:0];
        if (w_sum > SAT_MAX)      w_result = SAT_MAX[DATA_WIDTH-1:0];
        else if (w_sum < SAT_MIN) w_result = SAT_MIN[DATA_WIDTH-1:0];
        if (r_relu && w_sum[SUM_W-1]) w_result = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt         <= '0;
            r_ch          <= '0;
            r_filter      <= '0;
            r_bias        <= '0;
            r_relu        <= 1'b0;
            r_acc         <= '0;
            out_valid     <= 1'b0;
            unit_data_out <= '0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_filter <= filter_sel;
                    r_bias   <= data_bias;
                    r_relu   <= relu_enable;
                    r_acc    <= '0;
                    r_ch     <= '0;
                    r_cnt    <= '0;
                end
                S_LOAD:    r_cnt <= (r_cnt == CNT_W'(TAPS)) ? '0 : r_cnt + CNT_W'(1);
                S_WAIT_IF: r_cnt <= '0;
                S_MAC: begin
                    r_acc <= r_acc + ACC_WIDTH'(w_prod);
                    if (w_last_tap) begin
                        r_cnt <= '0;
                        if (!w_last_ch) r_ch <= r_ch + CH_W'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_OUT: begin
                    out_valid     <= 1'b1;
                    unit_data_out <= w_result;
                end
                default: ;
            endcase
        end
    end

    // NOTE: weight memory and tap registers carry no reset; their contents are always written before use.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE) begin
            if (wm_wr_en && (32'(wm_wr_addr) < WM_DEPTH)) r_wm[wm_wr_addr] <= riscv_data;
        end else if (r_state == S_LOAD && r_cnt < CNT_W'(TAPS)) begin
            r_rd_data <= (w_rd_addr < WM_DEPTH) ? r_wm[w_rd_addr[ADDRESS_SIZE_WM-1:0]] : '0;
        end
        if (r_state == S_LOAD && r_cnt != '0) r_w[w_w_idx] <= r_rd_data;
        if (r_state == S_WAIT_IF && if_valid) begin
            for (int i = 0; i < TAPS; i++) r_x[i] <= if_window[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_conv_unit_param.sv
// Self-checking bench for conv_unit_param (K=3, D=2): random and directed pixels checked
// against an arithmetic reference model of the convolution.
module tb_conv_unit_param;

    localparam int DW    = 16;
    localparam int FB    = 8;
    localparam int K     = 3;
    localparam int D     = 2;
    localparam int CF    = 16;
    localparam int KK    = K * K;
    localparam int DEPTH = KK * D * CF;
    localparam int AW    = $clog2(DEPTH);
    localparam int LAT   = D * (2 * KK + 2) + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               wm_wr_en;
    logic [AW-1:0]      wm_wr_addr;
    logic [DW-1:0]      riscv_data;
    logic               start;
    logic [$clog2(CF)-1:0] filter_sel;
    logic [DW-1:0]      data_bias;
    logic               relu_enable;
    logic [KK*DW-1:0]   if_window;
    logic               if_valid;
    logic               if_ready;
    logic               busy;
    logic               out_valid;
    logic [DW-1:0]      unit_data_out;

    conv_unit_param #(
        .DATA_WIDTH(DW), .FRAC_BITS(FB), .KERNAL_SIZE(K), .IFM_DEPTH(D), .CEIL_FILTERS(CF)
    ) dut (
        .clk(clk), .reset(reset), .wm_wr_en(wm_wr_en), .wm_wr_addr(wm_wr_addr),
        .riscv_data(riscv_data), .start(start), .filter_sel(filter_sel),
        .data_bias(data_bias), .relu_enable(relu_enable), .if_window(if_window),
        .if_valid(if_valid), .if_ready(if_ready), .busy(busy), .out_valid(out_valid),
        .unit_data_out(unit_data_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_wm [DEPTH];
    logic [DW-1:0] win [D][KK];

    function automatic logic [DW-1:0] expect_px(int f, logic [DW-1:0] b, bit relu);
        longint sum = 0;
        longint q;
        longint r;
        for (int ch = 0; ch < D; ch++)
            for (int i = 0; i < KK; i++)
                sum += longint'($signed(model_wm[(f*D+ch)*KK+i])) * longint'($signed(win[ch][i]));
        q = sum / 256;
        if (sum < 0 && (sum % 256) != 0) q = q - 1;
        r = q + longint'($signed(b));
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] gen_val(int kind, logic [DW-1:0] v);
        if (kind == 0) return v;
        if (kind == 1) return DW'($urandom);
        return DW'($urandom_range(0, 1023)) - DW'(512);
    endfunction

    task automatic wm_write(input int addr, input logic [DW-1:0] d);
        @(negedge clk);
        wm_wr_en = 1'b1; wm_wr_addr = AW'(addr); riscv_data = d;
        @(negedge clk);
        wm_wr_en = 1'b0;
        if (addr < DEPTH) model_wm[addr] = d;
    endtask

    task automatic fill_filter(input int f, input int kind, input logic [DW-1:0] v);
        for (int idx = 0; idx < D*KK; idx++) wm_write(f*D*KK + idx, gen_val(kind, v));
    endtask

    task automatic set_win(input int kind, input logic [DW-1:0] v);
        for (int ch = 0; ch < D; ch++)
            for (int i = 0; i < KK; i++) win[ch][i] = gen_val(kind, v);
    endtask

    // Runs one pixel; poke drives a WM write and starts while busy, including during OUT.
    task automatic run_pixel(input int f, input logic [DW-1:0] b, input bit relu,
                             input int stall, input bit poke,
                             output logic [DW-1:0] res, output int lat, output int ready_cnt);
        int n, ch, st, busy_low;
        bit done;
        @(negedge clk);
        start = 1'b1; filter_sel = ($clog2(CF))'(f); data_bias = b; relu_enable = relu;
        @(posedge clk);
        n = 0; ch = 0; st = stall; done = 0; lat = -1; ready_cnt = 0; busy_low = 0; res = '0;
        @(negedge clk);
        start = 1'b0; filter_sel = ($clog2(CF))'($urandom);
        data_bias = DW'($urandom); relu_enable = 1'($urandom);
        while (!done && n < 600) begin
            if (out_valid) begin
                done = 1; lat = n; res = unit_data_out;
            end else begin
                if (!busy) busy_low++;
                if (if_ready) begin
                    ready_cnt++;
                    if (st > 0) begin
                        if_valid = 1'b0; st--;
                    end else begin
                        if_valid = 1'b1;
                        for (int i = 0; i < KK; i++)
                            if_window[i*DW +: DW] = (ch < D) ? win[ch][i] : DW'($urandom);
                        ch++; st = stall;
                    end
                end else begin
                    if_valid = 1'($urandom);
                    for (int i = 0; i < KK; i++) if_window[i*DW +: DW] = DW'($urandom);
                end
                wm_wr_en = poke && (n == 5);
                wm_wr_addr = AW'(f*D*KK); riscv_data = ~model_wm[f*D*KK];
                start = poke && (n == 20 || n == LAT - 1 + 2*stall);
                @(posedge clk); n++; @(negedge clk);
            end
        end
        start = 1'b0; wm_wr_en = 1'b0; if_valid = 1'b0;
        total++;
        if (!done) begin
            bad++; $display("FAIL timeout: no out_valid within %0d cycles", n);
        end
        total++;
        if (busy_low !== 0) begin
            bad++; $display("FAIL busy_gap: busy low %0d cycles, required 0", busy_low);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL idle_after_out: busy=%b required 0", busy);
        end
        @(posedge clk); @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || unit_data_out !== res) begin
            bad++;
            $display("FAIL pulse_hold: out_valid=%b data=%h required 0 and %h", out_valid, unit_data_out, res);
        end
    endtask

    task automatic check_px(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        // used only for named pixel comparisons below; each call is one comparison
        total++;
        if (got !== want) begin
            bad++; $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wm_wr_en = 0; wm_wr_addr = '0; riscv_data = '0; start = 0;
        filter_sel = '0; data_bias = '0; relu_enable = 0; if_window = '0; if_valid = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({if_ready, busy, out_valid, unit_data_out} !== '0) begin
            bad++;
            $display("FAIL reset_state: ready=%b busy=%b valid=%b data=%h required all 0",
                     if_ready, busy, out_valid, unit_data_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [DW-1:0] r; int lat, rc;
        fill_filter(0, 0, 16'h0100);
        set_win(0, 16'h0100);
        run_pixel(0, 16'h0000, 1'b0, 0, 1'b0, r, lat, rc);
        if (r !== expect_px(0, 16'h0000, 1'b0)) begin
            total++; bad++; $display("FAIL basic_model: got %h required %h", r, expect_px(0, 0, 0));
        end else total++;
        check_px("basic_const", r, 16'h1200);
        total++;
        if (lat !== LAT) begin bad++; $display("FAIL latency: got %0d required %0d", lat, LAT); end
        total++;
        if (rc !== D) begin bad++; $display("FAIL ready_cycles: got %0d required %0d", rc, D); end
    endtask

    task automatic test_sign_relu();
        logic [DW-1:0] r; int lat, rc;
        set_win(0, 16'hFF00);
        run_pixel(0, 16'h0080, 1'b0, 0, 1'b0, r, lat, rc);
        check_px("negative", r, 16'hEE80);
        run_pixel(0, 16'h0080, 1'b1, 0, 1'b0, r, lat, rc);
        check_px("relu", r, 16'h0000);
    endtask

    task automatic test_saturation();
        logic [DW-1:0] r; int lat, rc;
        fill_filter(3, 0, 16'h7FFF);
        set_win(0, 16'h7FFF);
        run_pixel(3, 16'h7FFF, 1'b0, 0, 1'b0, r, lat, rc);
        check_px("sat_pos", r, 16'h7FFF);
        set_win(0, 16'h8000);
        run_pixel(3, 16'h8000, 1'b0, 0, 1'b0, r, lat, rc);
        check_px("sat_neg", r, 16'h8000);
    endtask

    task automatic test_stall();
        logic [DW-1:0] r0, r1, b; int lat0, lat1, rc0, rc1;
        fill_filter(5, 2, '0);
        set_win(2, '0);
        b = gen_val(2, '0);
        run_pixel(5, b, 1'b0, 0, 1'b0, r0, lat0, rc0);
        run_pixel(5, b, 1'b0, 10, 1'b0, r1, lat1, rc1);
        check_px("stall_ref", r0, expect_px(5, b, 1'b0));
        check_px("stall_same", r1, expect_px(5, b, 1'b0));
        total++;
        if (lat1 !== LAT + 2*10) begin
            bad++; $display("FAIL stall_latency: got %0d required %0d", lat1, LAT + 20);
        end
        total++;
        if (rc1 !== D*11) begin
            bad++; $display("FAIL stall_ready: got %0d required %0d", rc1, D*11);
        end
    endtask

    task automatic test_filters();
        logic [DW-1:0] r; int lat, rc;
        fill_filter(0, 2, '0);
        fill_filter(15, 2, '0);
        wm_write(DEPTH + 5, 16'hDEAD);
        set_win(2, '0);
        run_pixel(0, 16'h0010, 1'b0, 0, 1'b0, r, lat, rc);
        check_px("filter0", r, expect_px(0, 16'h0010, 1'b0));
        run_pixel(15, 16'hFFF0, 1'b0, 0, 1'b0, r, lat, rc);
        check_px("filter15", r, expect_px(15, 16'hFFF0, 1'b0));
        run_pixel(15, 16'hFFF0, 1'b0, 0, 1'b1, r, lat, rc);
        check_px("busy_poke", r, expect_px(15, 16'hFFF0, 1'b0));
        run_pixel(15, 16'hFFF0, 1'b0, 0, 1'b0, r, lat, rc);
        check_px("wm_unchanged", r, expect_px(15, 16'hFFF0, 1'b0));
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] r; int lat, rc, n, vcount;
        set_win(2, '0);
        @(negedge clk);
        start = 1'b1; filter_sel = 4'd15; data_bias = '0; relu_enable = 1'b0;
        @(posedge clk); @(negedge clk); start = 1'b0;
        n = 0;
        while (n < 13) begin
            if_valid = if_ready;
            for (int i = 0; i < KK; i++) if_window[i*DW +: DW] = win[0][i];
            @(posedge clk); n++; @(negedge clk);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({if_ready, busy, out_valid, unit_data_out} !== '0) begin
            bad++;
            $display("FAIL reset_mid: ready=%b busy=%b valid=%b data=%h required all 0",
                     if_ready, busy, out_valid, unit_data_out);
        end
        @(negedge clk); reset = 1'b0; if_valid = 1'b1;
        vcount = 0;
        repeat (60) begin @(negedge clk); if (out_valid || busy) vcount++; end
        if_valid = 1'b0;
        total++;
        if (vcount !== 0) begin
            bad++; $display("FAIL reset_no_output: %0d active cycles, required 0", vcount);
        end
        run_pixel(15, 16'h0123, 1'b0, 0, 1'b0, r, lat, rc);
        check_px("after_reset", r, expect_px(15, 16'h0123, 1'b0));
    endtask

    task automatic test_random();
        logic [DW-1:0] r, b; int lat, rc, f; bit relu;
        for (int it = 0; it < 6; it++) begin
            f = $urandom_range(0, CF-1);
            fill_filter(f, (it % 3 == 0) ? 1 : 2, '0);
            set_win((it % 3 == 0) ? 1 : 2, '0);
            b = DW'($urandom);
            relu = 1'($urandom);
            run_pixel(f, b, relu, $urandom_range(0, 3), 1'b0, r, lat, rc);
            check_px("random", r, expect_px(f, b, relu));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_relu();
        test_saturation();
        test_stall();
        test_filters();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
